// File: rtl/cv32e40p_x_coproc.sv
// X-interface coprocessor: decodes custom-0 ADD3/MUL, queues accepted ops, executes in order, returns rd results.
// Latency: ADD3 result 3 cycles after issue into an idle unit, MUL 34; results held until x_rready_i.
module cv32e40p_x_coproc #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             x_valid_i,
  output logic             x_ready_o,
  output logic             x_accept_o,
  output logic             x_writeback_o,
  output logic             x_is_mem_op_o,
  input  logic [31:0]      x_instr_i,
  input  logic [2:0][31:0] x_rs_i,
  input  logic [2:0]       x_rs_valid_i,
  output logic             x_rvalid_o,
  input  logic             x_rready_i,
  output logic [4:0]       x_rwaddr_o,
  output logic [31:0]      x_rdata_o
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned NW   = $clog2(DEPTH + 1);
  localparam int unsigned CW   = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [6:0]  OPC_CUSTOM0 = 7'b0001011;

  typedef struct packed {
    logic        is_mul;
    logic [4:0]  rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rs3;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  // Decode
  logic       dec_add3, dec_mul, ops_ready, fifo_full, push, pop;
  logic [2:0] rs_need;
  logic       unused_instr;

  assign dec_add3 = (x_instr_i[6:0] == OPC_CUSTOM0) && (x_instr_i[14:12] == 3'b000);
  assign dec_mul  = (x_instr_i[6:0] == OPC_CUSTOM0) && (x_instr_i[14:12] == 3'b001);
  assign rs_need  = dec_add3 ? 3'b111 : (dec_mul ? 3'b011 : 3'b000);
  assign ops_ready = &(x_rs_valid_i | ~rs_need);
  assign unused_instr = ^x_instr_i[31:15];

  assign x_accept_o    = dec_add3 | dec_mul;
  assign x_writeback_o = x_accept_o & (x_instr_i[11:7] != 5'd0);
  assign x_is_mem_op_o = 1'b0;
  assign x_ready_o     = x_accept_o ? (~fifo_full & ops_ready) : 1'b1;
  assign push          = x_valid_i & x_ready_o & x_accept_o;

  // Instruction FIFO
  entry_t          fifo_mem [DEPTH];
  entry_t          push_ent, head;
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [NW-1:0]   count_q;
  state_e          state_q, state_d;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full = (count_q == NW'(DEPTH));
  assign pop       = (state_q == S_IDLE) && (count_q != '0);
  assign head      = fifo_mem[rptr_q];

  always_comb begin
    push_ent        = '0;
    push_ent.is_mul = dec_mul;
    push_ent.rd     = x_instr_i[11:7];
    push_ent.rs1    = x_rs_i[0];
    push_ent.rs2    = x_rs_i[1];
    push_ent.rs3    = dec_add3 ? x_rs_i[2] : 32'd0;
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr_q] <= push_ent;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + NW'(1);
        2'b01:   count_q <= count_q - NW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Execution unit; for MUL, a/b act as shifting multiplicand/multiplier
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   acc_q, acc_d, a_q, a_d, b_q, b_d, c_q, c_d;
  logic          is_mul_q, is_mul_d;
  logic [4:0]    rd_q, rd_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      is_mul_q <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      is_mul_q <= is_mul_d;
      rd_q     <= rd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    is_mul_d = is_mul_q;
    rd_d     = rd_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          is_mul_d = head.is_mul;
          rd_d     = head.rd;
          a_d      = head.rs1;
          b_d      = head.rs2;
          c_d      = head.rs3;
          acc_d    = '0;
          cnt_d    = head.is_mul ? CW'(MUL_CYCLES - 1) : '0;
          state_d  = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_mul_q) begin
          if (b_q[0]) acc_d = acc_q + a_q;
          a_d = a_q << 1;
          b_d = b_q >> 1;
          if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end else begin
          acc_d = a_q + b_q + c_q;
        end
        // Writes to x0 retire silently
        if (cnt_q == '0) state_d = (rd_q != 5'd0) ? S_RESP : S_IDLE;
      end
      S_RESP: begin
        if (x_rready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign x_rvalid_o = (state_q == S_RESP);
  assign x_rwaddr_o = x_rvalid_o ? rd_q  : 5'd0;
  assign x_rdata_o  = x_rvalid_o ? acc_q : 32'd0;

endmodule
